// File: rtl/player_bullet_manager.sv
// Player bullet pool: spawns on fire edges, moves live bullets up once per frame,
// and folds in kill results from the collision stage during a short per-frame pass.
//
// state | meaning
// IDLE  | waiting for a frame tick
// MERGE | apply post-collision alive bits; killed slots become NONE
// MOVE  | advance live bullets upward, tick the cooldown down
// SPAWN | serve a pending fire request into the lowest free slot
// DONE  | pulse o_UpdateDone, return to IDLE
module player_bullet_manager #(
    parameter int          MAX_PLAYER_BULLET = 4,
    parameter int          MONITOR_HEIGHT    = 480,
    parameter int          PLAYER_WIDTH      = 32,
    parameter int          PLAYER_Y          = 440,
    parameter int          BULLET_WIDTH      = 4,
    parameter int          BULLET_HEIGHT     = 8,
    parameter int          BULLET_SPEED      = 4,
    parameter int          FIRE_COOLDOWN     = 8,
    parameter logic [18:0] NONE              = 19'h7FFFF
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_n,
    input  logic                            i_FrameTick,
    input  logic                            i_Fire,
    input  logic [9:0]                      i_PlayerPosition,
    input  logic [MAX_PLAYER_BULLET-1:0]    i_PostState,
    output logic [MAX_PLAYER_BULLET-1:0]    o_PlayerBulletState,
    output logic [19*MAX_PLAYER_BULLET-1:0] o_PlayerBulletPosition,
    output logic                            o_Busy,
    output logic                            o_UpdateDone
);

    localparam logic [9:0] X_OFFSET = 10'((PLAYER_WIDTH - BULLET_WIDTH) / 2);
    localparam logic [8:0] SPAWN_Y  = 9'(PLAYER_Y - BULLET_HEIGHT);
    localparam logic [8:0] SPEED    = 9'(BULLET_SPEED);
    localparam logic [7:0] COOLDOWN = 8'(FIRE_COOLDOWN);

    typedef enum logic [2:0] {IDLE, MERGE, MOVE, SPAWN, DONE} fsm_t;

    fsm_t                         fsm;
    logic [MAX_PLAYER_BULLET-1:0] alive;
    logic [18:0]                  pos [MAX_PLAYER_BULLET];
    logic [7:0]                   cooldown;
    logic                         fire_prev;
    logic                         fire_pending;
    logic                         busy;
    logic                         update_done;
    logic [MAX_PLAYER_BULLET-1:0] free_onehot;
    logic                         free_taken;

    // One-hot pick of the lowest-index free slot
    always_comb begin
        free_onehot = '0;
        free_taken  = 1'b0;
        for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
            if (!alive[k] && !free_taken) begin
                free_onehot[k] = 1'b1;
                free_taken     = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            fsm          <= IDLE;
            alive        <= '0;
            for (int k = 0; k < MAX_PLAYER_BULLET; k++) pos[k] <= NONE;
            cooldown     <= '0;
            fire_prev    <= 1'b0;
            fire_pending <= 1'b0;
            busy         <= 1'b0;
            update_done  <= 1'b0;
        end else begin
            fire_prev   <= i_Fire;
            update_done <= 1'b0;
            if (i_Fire && !fire_prev) fire_pending <= 1'b1;

            case (fsm)
                IDLE: begin
                    if (i_FrameTick) begin
                        fsm  <= MERGE;
                        busy <= 1'b1;
                    end
                end
                MERGE: begin
                    for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
                        alive[k] <= alive[k] & i_PostState[k];
                        if (alive[k] && !i_PostState[k]) pos[k] <= NONE;
                    end
                    fsm <= MOVE;
                end
                MOVE: begin
                    // Bullets clamp at y=0 and stay live so the top-border hit is seen next frame
                    for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
                        if (alive[k]) begin
                            if (pos[k][8:0] <= SPEED) pos[k][8:0] <= 9'd0;
                            else                      pos[k][8:0] <= pos[k][8:0] - SPEED;
                        end
                    end
                    if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
                    fsm <= SPAWN;
                end
                SPAWN: begin
                    // Clearing here also discards an edge arriving in this same cycle
                    fire_pending <= 1'b0;
                    if (fire_pending && (cooldown == 8'd0) && free_taken) begin
                        for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
                            if (free_onehot[k]) begin
                                alive[k] <= 1'b1;
                                pos[k]   <= {i_PlayerPosition + X_OFFSET, SPAWN_Y};
                            end
                        end
                        cooldown <= COOLDOWN;
                    end
                    update_done <= 1'b1;
                    fsm         <= DONE;
                end
                DONE: begin
                    busy <= 1'b0;
                    fsm  <= IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    fsm  <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < MAX_PLAYER_BULLET; g++) begin : g_pack
        assign o_PlayerBulletPosition[19*g +: 19] = pos[g];
    end

    assign o_PlayerBulletState = alive;
    assign o_Busy              = busy;
    assign o_UpdateDone        = update_done;

endmodule

// File: tb/tb_player_bullet_manager.sv
// Bench for player_bullet_manager: directed scenarios plus randomized frames,
// checked against a slot-list reference model.
module tb_player_bullet_manager;

    localparam int          N    = 4;
    localparam logic [18:0] NONE = 19'h7FFFF;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           tick = 1'b0;
    logic           fire = 1'b0;
    logic [9:0]     px = 10'd0;
    logic [N-1:0]   post = '1;
    logic [N-1:0]   st;
    logic [19*N-1:0] pos;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    // reference model
    bit m_alive [N];
    int m_x [N];
    int m_y [N];
    int m_cd;
    bit m_pend;
    bit m_fprev;

    always #5 clk = ~clk;

    player_bullet_manager dut (
        .i_Clk                  (clk),
        .i_Rst_n                (rst_n),
        .i_FrameTick            (tick),
        .i_Fire                 (fire),
        .i_PlayerPosition       (px),
        .i_PostState            (post),
        .o_PlayerBulletState    (st),
        .o_PlayerBulletPosition (pos),
        .o_Busy                 (busy),
        .o_UpdateDone           (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_alive[k] = 1'b0;
            m_x[k] = 0;
            m_y[k] = 0;
        end
        m_cd = 0;
        m_pend = 1'b0;
        m_fprev = 1'b0;
    endtask

    task automatic model_frame(input logic [N-1:0] pm);
        int fk;
        for (int k = 0; k < N; k++)
            if (m_alive[k] && !pm[k]) m_alive[k] = 1'b0;
        for (int k = 0; k < N; k++)
            if (m_alive[k]) m_y[k] = (m_y[k] <= 4) ? 0 : m_y[k] - 4;
        if (m_cd > 0) m_cd--;
        if (m_pend && m_cd == 0) begin
            fk = -1;
            for (int k = 0; k < N; k++)
                if (!m_alive[k] && fk < 0) fk = k;
            if (fk >= 0) begin
                m_alive[fk] = 1'b1;
                m_x[fk] = (int'(px) + 14) % 1024;
                m_y[fk] = 432;
                m_cd = 8;
            end
        end
        m_pend = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] es;
        logic [18:0]  ep;
        for (int k = 0; k < N; k++) es[k] = m_alive[k];
        check({tag, "_state"}, 32'(st), 32'(es));
        for (int k = 0; k < N; k++) begin
            ep = m_alive[k] ? {10'(m_x[k]), 9'(m_y[k])} : NONE;
            check($sformatf("%s_pos%0d", tag, k), 32'(pos[19*k +: 19]), 32'(ep));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(st), 32'd0);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_pos%0d", tag, k), 32'(pos[19*k +: 19]), 32'(NONE));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic set_fire(input logic f);
        fire = f;
        if (f && !m_fprev) m_pend = 1'b1;
        m_fprev = f;
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic [N-1:0] pm, input string tag);
        int n;
        post = pm;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
        model_frame(pm);
        check_model(tag);
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        fire = 1'b0;
        tick = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0] pm;
        int alive_cnt;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // idle frame with no fire
        frame('1, "idle_frame");

        // spawn at player x=100, then one move; held fire spawns nothing more
        px = 10'd100;
        set_fire(1'b1);
        frame('1, "spawn");
        check("spawn_slot0", 32'(pos[18:0]), 32'({10'd114, 9'd432}));
        frame('1, "move1");
        check("move_slot0", 32'(pos[18:0]), 32'({10'd114, 9'd428}));
        frame('1, "held");
        check("held_state", 32'(st), 32'd1);

        // cooldown: edges before ticks 1, 2 and 9 -> spawns on 1 and 9
        do_reset();
        for (int t = 1; t <= 9; t++) begin
            if (t == 1 || t == 2 || t == 9) begin
                set_fire(1'b0);
                set_fire(1'b1);
            end
            frame('1, $sformatf("cd_t%0d", t));
            if (t == 2) check("cd_tick2_state", 32'(st), 32'd1);
        end
        check("cd_tick9_state", 32'(st), 32'b0011);
        set_fire(1'b0);

        // run slot0 to the top border; it stays live at y=0, then gets killed
        for (int i = 0; i < 120 && m_y[0] != 0; i++) frame('1, "climb");
        check("top_alive", 32'(st[0]), 32'd1);
        check("top_y", 32'(pos[8:0]), 32'd0);
        frame(4'b1110, "top_kill");
        check("kill_pos", 32'(pos[18:0]), 32'(NONE));

        // fill all slots, then kill slot2 and refill it in the same pass
        do_reset();
        px = 10'd300;
        for (int i = 0; i < 60; i++) begin
            alive_cnt = 0;
            for (int k = 0; k < N; k++) alive_cnt += int'(m_alive[k]);
            if (alive_cnt == N && m_cd == 1) break;
            set_fire(1'b0);
            set_fire(1'b1);
            frame('1, "fill");
        end
        check("fill_state", 32'(st), 32'b1111);
        set_fire(1'b0);
        set_fire(1'b1);
        frame(4'b1011, "reuse");
        check("reuse_state", 32'(st), 32'b1111);
        check("reuse_slot2", 32'(pos[38 +: 19]), 32'({10'd314, 9'd432}));
        set_fire(1'b0);

        // asynchronous reset during MOVE
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        frame('1, "post_rst");
        set_fire(1'b1);
        frame('1, "post_rst_spawn");
        check("post_rst_spawn_state", 32'(st), 32'd1);

        // randomized frames
        for (int i = 0; i < 200; i++) begin
            px = 10'($urandom);
            set_fire(1'($urandom_range(0, 1)));
            for (int k = 0; k < N; k++) pm[k] = ($urandom_range(0, 3) != 0);
            frame(pm, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
